// File: rtl/y_signature_misr_pkg.sv
// Shared types and defaults for the y-bus signature MISR and its XOR fold.
package y_signature_misr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [31:0] MISR_POLY_DEF = 32'h04C11DB7;
  localparam logic [31:0] MISR_SEED_DEF = 32'hFFFFFFFF;

  // Number of 32-bit words needed to hold a y bus of the given width.
  function automatic int fold_words(input int y_w);
    return (y_w + 31) / 32;
  endfunction

endpackage

// File: rtl/y_signature_misr_y_fold_xor.sv
// Combinational fold of an arbitrary-width y bus into 32 bits by XOR of its words.
module y_fold_xor
  import y_signature_misr_pkg::*;
#(
  parameter int Y_W = 1340
) (
  input  logic [Y_W-1:0] y_i,
  output logic [31:0]    fold_o
);

  localparam int NW = fold_words(Y_W);

  logic [NW*32-1:0] padded;

  // Upper bits of the last word are zero so partial words fold cleanly.
  always_comb begin
    padded            = '0;
    padded[Y_W-1:0]   = y_i;
    fold_o            = '0;
    for (int w = 0; w < NW; w++) begin
      fold_o = fold_o ^ padded[w*32 +: 32];
    end
  end

endmodule

// File: rtl/y_signature_misr.sv
// Compresses a wide y result bus into a 32-bit MISR signature over a programmed sample count.
module y_signature_misr
  import y_signature_misr_pkg::*;
#(
  parameter int          Y_W   = 1340,
  parameter logic [31:0] POLY  = MISR_POLY_DEF,
  parameter logic [31:0] SEED  = MISR_SEED_DEF,
  parameter int          CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic [Y_W-1:0]   y_in,
  input  logic             y_valid,
  input  logic [31:0]      expected_sig,
  output logic             busy,
  output logic             done,
  output logic [31:0]      signature,
  output logic             match,
  output logic [CNT_W-1:0] sample_cnt
);

  state_e           state_q, state_d;
  logic [31:0]      sig_q, sig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic             match_q, match_d;
  logic [31:0]      fold;
  logic [31:0]      sig_step;
  logic [CNT_W-1:0] cnt_inc;

  function automatic logic [31:0] misr_step(input logic [31:0] sig, input logic [31:0] din);
    return {sig[30:0], 1'b0} ^ (sig[31] ? POLY : 32'h0) ^ din;
  endfunction

  y_fold_xor #(
    .Y_W (Y_W)
  ) u_fold (
    .y_i    (y_in),
    .fold_o (fold)
  );

  assign sig_step = misr_step(sig_q, fold);
  assign cnt_inc  = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    match_d = match_q;

    // start wins in every state; the sample on the start edge is never absorbed.
    if (start) begin
      sig_d   = SEED;
      cnt_d   = '0;
      num_d   = num_samples;
      if (num_samples == '0) begin
        state_d = DONE;
        match_d = (SEED == expected_sig);
      end else begin
        state_d = RUN;
        match_d = 1'b0;
      end
    end else begin
      unique case (state_q)
        RUN: begin
          if (y_valid) begin
            sig_d = sig_step;
            cnt_d = cnt_inc;
            if (cnt_inc == num_q) begin
              state_d = DONE;
              match_d = (sig_step == expected_sig);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      num_q   <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      match_q <= match_d;
    end
  end

  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign signature  = sig_q;
  assign match      = match_q;
  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_y_signature_misr.sv
// Self-checking bench for y_signature_misr: vector table plus scoreboard of final signatures.
module tb_y_signature_misr;

  localparam int          Y_W   = 1340;
  localparam int          CNT_W = 16;
  localparam logic [31:0] POLY  = 32'h04C11DB7;
  localparam logic [31:0] SEED  = 32'hFFFFFFFF;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] num_samples;
  logic [Y_W-1:0]   y_in;
  logic             y_valid;
  logic [31:0]      expected_sig;
  logic             busy;
  logic             done;
  logic [31:0]      signature;
  logic             match;
  logic [CNT_W-1:0] sample_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int unsigned num;
    logic [15:0] vpat;   // valid pattern, bit 0 first; all-ones after 16 cycles
    int          ykind;  // 0 zero, 1 bits 0 and 32, 2 random
    logic        flip;   // corrupt one bit of expected_sig
  } vec_t;

  typedef struct {
    logic [31:0] sig;
    logic        m;
    int          cnt;
  } exp_t;

  exp_t exp_q[$];

  y_signature_misr #(
    .Y_W   (Y_W),
    .POLY  (POLY),
    .SEED  (SEED),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_samples  (num_samples),
    .y_in         (y_in),
    .y_valid      (y_valid),
    .expected_sig (expected_sig),
    .busy         (busy),
    .done         (done),
    .signature    (signature),
    .match        (match),
    .sample_cnt   (sample_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] model_fold(input logic [Y_W-1:0] y);
    logic [31:0] f;
    f = '0;
    for (int i = 0; i < Y_W; i++) f[i % 32] = f[i % 32] ^ y[i];
    return f;
  endfunction

  function automatic logic [31:0] model_step(input logic [31:0] s, input logic [31:0] d);
    logic [31:0] n;
    n = s << 1;
    if (s[31]) n = n ^ POLY;
    return n ^ d;
  endfunction

  function automatic logic [Y_W-1:0] gen_y(input int kind);
    logic [Y_W-1:0] y;
    y = '0;
    if (kind == 1) begin
      y[0]  = 1'b1;
      y[32] = 1'b1;
    end else if (kind == 2) begin
      for (int i = 0; i < Y_W; i++) y[i] = 1'($urandom_range(0, 1));
    end
    return y;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    logic [31:0] ms;
    int          mc;
    bit          fin;
    int          k;
    exp_t        e;
    logic        vld;
    ms  = SEED;
    mc  = 0;
    fin = 1'b0;
    @(negedge clk);
    start        = 1'b1;
    num_samples  = CNT_W'(v.num);
    y_valid      = 1'b1;
    y_in         = gen_y(2);
    expected_sig = SEED ^ {31'b0, v.flip};
    if (v.num == 0) begin
      exp_q.push_back('{sig: SEED, m: !v.flip, cnt: 0});
      fin = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    chk({tag, " cnt_after_start"}, 32'(sample_cnt), 32'(0));
    chk({tag, " busy_after_start"}, 32'(busy), 32'(v.num != 0));
    k = 0;
    while (!fin && k < 300) begin
      vld     = (k < 16) ? v.vpat[k] : 1'b1;
      y_valid = vld;
      y_in    = gen_y(v.ykind);
      if (vld) begin
        ms = model_step(ms, model_fold(y_in));
        mc++;
        if (mc == int'(v.num)) begin
          expected_sig = ms ^ {31'b0, v.flip};
          exp_q.push_back('{sig: ms, m: !v.flip, cnt: mc});
          fin = 1'b1;
        end
      end
      chk({tag, " busy_run"}, 32'(busy), 32'(1));
      @(negedge clk);
      chk({tag, " cnt_step"}, 32'(sample_cnt), 32'(mc));
      k++;
    end
    y_valid = 1'b0;
    if (!fin) begin
      chk({tag, " timeout"}, 32'(0), 32'(1));
    end else begin
      chk({tag, " done"}, 32'(done), 32'(1));
      chk({tag, " busy_done"}, 32'(busy), 32'(0));
      if (exp_q.size() == 0) begin
        chk({tag, " scoreboard_empty"}, 32'(0), 32'(1));
      end else begin
        e = exp_q.pop_front();
        chk({tag, " signature"}, signature, e.sig);
        chk({tag, " match"}, 32'(match), 32'(e.m));
        chk({tag, " cnt_final"}, 32'(sample_cnt), 32'(e.cnt));
      end
      // DONE must ignore further valid samples.
      y_valid = 1'b1;
      y_in    = gen_y(2);
      @(negedge clk);
      y_valid = 1'b0;
      chk({tag, " done_hold"}, 32'(done), 32'(1));
      chk({tag, " sig_frozen"}, signature, e.sig);
    end
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{num: 1, vpat: 16'h0001, ykind: 0, flip: 1'b0};
    vecs[1] = '{num: 0, vpat: 16'h0000, ykind: 0, flip: 1'b0};
    vecs[2] = '{num: 1, vpat: 16'h0001, ykind: 1, flip: 1'b0};
    vecs[3] = '{num: 3, vpat: 16'h0019, ykind: 2, flip: 1'b0};
    vecs[4] = '{num: 5, vpat: 16'hA5A5, ykind: 2, flip: 1'b0};
    vecs[5] = '{num: 7, vpat: 16'hFFFF, ykind: 2, flip: 1'b1};
    vecs[6] = '{num: 0, vpat: 16'h0000, ykind: 0, flip: 1'b1};
    vecs[7] = '{num: 20, vpat: 16'h0F0F, ykind: 2, flip: 1'b0};

    rst_n        = 1'b0;
    start        = 1'b0;
    num_samples  = '0;
    y_in         = '0;
    y_valid      = 1'b0;
    expected_sig = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset busy", 32'(busy), 32'(0));
    chk("reset done", 32'(done), 32'(0));
    chk("reset match", 32'(match), 32'(0));
    chk("reset sig", signature, SEED);
    chk("reset cnt", 32'(sample_cnt), 32'(0));

    // Valid on an IDLE cycle without start must not be absorbed.
    y_valid = 1'b1;
    y_in    = gen_y(2);
    @(negedge clk);
    y_valid = 1'b0;
    chk("idle ignores valid", signature, SEED);

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
      if (i == 0 || i == 2) chk($sformatf("vec%0d golden", i), signature, 32'hFB3EE249);
      if (i == 1) chk("vec1 seed sig", signature, 32'hFFFFFFFF);
    end

    // Restart mid-DONE (previous vector left the DUT in DONE).
    @(negedge clk);
    start       = 1'b1;
    num_samples = 16'd2;
    @(negedge clk);
    start = 1'b0;
    chk("restart done low", 32'(done), 32'(0));
    chk("restart busy", 32'(busy), 32'(1));
    chk("restart sig seed", signature, SEED);

    // Asynchronous reset in RUN after 2 of 4 samples.
    start       = 1'b1;
    num_samples = 16'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (2) begin
      y_valid = 1'b1;
      y_in    = gen_y(2);
      @(negedge clk);
    end
    y_valid = 1'b0;
    chk("pre-abort cnt", 32'(sample_cnt), 32'(2));
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 32'(0));
    chk("abort done", 32'(done), 32'(0));
    chk("abort sig", signature, SEED);
    chk("abort cnt", 32'(sample_cnt), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-abort idle busy", 32'(busy), 32'(0));
    run_vec('{num: 1, vpat: 16'h0001, ykind: 0, flip: 1'b0}, "after_abort");
    chk("after_abort golden", signature, 32'hFB3EE249);
    run_vec('{num: 4, vpat: 16'h00FF, ykind: 2, flip: 1'b0}, "after_abort4");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/y_signature_misr.md
Name: y_signature_misr

Overview:
- Consumes the wide `y` result bus of the design-under-test modules, such as the 1340-bit `y` of module282, directly downstream of them.
- Compresses `y` into a 32-bit running signature with a multiple-input signature register (MISR) over a programmed number of valid samples.
- Exposes the final signature and a compare-against-expected flag, so two netlists can be checked for equivalence by signature only.

Parameters:
- Y_W, 1340, width of the consumed `y` bus (bits).
- POLY, 32'h04C11DB7, MISR feedback polynomial.
- SEED, 32'hFFFFFFFF, signature value loaded at start.
- CNT_W, 16, width of the sample counter and of num_samples.

Ports:
- clk  input  1  rising-edge clock, shared with the upstream producer.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that begins a capture run.
- num_samples  input  CNT_W  number of valid samples per run; latched on start.
- y_in  input  Y_W  `y` bus from the upstream module.
- y_valid  input  1  y_in carries a sample this cycle.
- expected_sig  input  32  golden signature; sampled on the entry into DONE.
- busy  output  1  high while in RUN.
- done  output  1  high while in DONE.
- signature  output  32  current MISR state.
- match  output  1  signature == expected_sig; valid only while done = 1.
- sample_cnt  output  CNT_W  samples absorbed in the current run.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state = IDLE.
  - signature = SEED, sample_cnt = 0.
  - busy = 0, done = 0, match = 0.
  - Reset mid-run aborts the run with no residual state.
- Fold (combinational):
  - Zero-pad y_in to 32*ceil(Y_W/32) bits.
  - fold = XOR of all 32-bit words; word 0 = y_in[31:0].
  - Y_W = 1340 gives 42 words.
- MISR step: next = {sig[30:0],1'b0} ^ (sig[31] ? POLY : 0) ^ fold.
- IDLE:
  - On start: signature <= SEED, sample_cnt <= 0, latch num_samples.
  - Latched num_samples == 0: go to DONE.
  - Otherwise go to RUN.
  - y_valid is ignored in IDLE.
- RUN:
  - Each cycle with y_valid = 1: signature <= MISR step, sample_cnt <= sample_cnt + 1.
  - Cycles with y_valid = 0: hold all state.
  - On the valid cycle where sample_cnt + 1 == latched count, go to DONE next edge.
- DONE:
  - done = 1; signature and sample_cnt are frozen.
  - match is registered on the DONE entry edge from the signature being written that edge and expected_sig.
  - Stays in DONE until the next start.
- Latency: done rises on the edge after the final valid sample; match is valid in the same cycle.
- start while in RUN or DONE: restarts exactly as from IDLE; the prior result is discarded and done deasserts on the next edge.
- start together with y_valid on the start edge: that sample is NOT absorbed; capture begins on the following cycle.
- sample_cnt cannot wrap, because the run terminates at num_samples ≤ 2^CNT_W − 1.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, RUN, DONE);
  - the POLY and SEED defaults;
  - a function computing the word count ceil(Y_W/32).
- One natural sub-module: y_fold_xor. It is the purely combinational Y_W-to-32 XOR fold, parameterised by Y_W, and is reusable for other `y` widths such as 889 bits.

Test Plan:
- Reset then start with num_samples = 1, one valid cycle with y_in = 0 -> done = 1 next cycle, signature = 32'hFB3EE249, sample_cnt = 1.
- Start with num_samples = 0 -> done asserts one cycle after start; signature = 32'hFFFFFFFF; match = 1 when expected_sig = 32'hFFFFFFFF.
- num_samples = 1, y_in with only bits 0 and 32 set (Y_W = 1340) -> fold cancels; signature = 32'hFB3EE249, identical to the all-zero case.
- num_samples = 3 with y_valid pattern 1,0,0,1,1 -> busy for 5 cycles; sample_cnt steps 1,1,1,2,3; done after the fifth cycle.
- Drop rst_n low in RUN after 2 of 4 samples -> immediate IDLE with signature = SEED and busy = 0; a fresh run then reproduces the golden result.
- Complete a run with expected_sig off by one bit -> match = 0; start again mid-DONE -> done = 0 on the next edge.
